// File: rtl/spell_pkg.sv
// Shared definitions for the SPELL core data stack.
//   op_t : stack operation codes issued by instruction decode.
package spell_pkg;

   typedef enum logic [2:0] {
      NOP  = 3'd0,
      PUSH = 3'd1,
      POP  = 3'd2,
      DUP  = 3'd3,
      SWAP = 3'd4,
      OVER = 3'd5,
      REPL = 3'd6,
      ROT  = 3'd7
   } op_t;

endpackage

// File: rtl/spell_data_stack.sv
// Data stack for the SPELL execute stage. One op per cycle from decode.
// TOS/NOS are presented combinationally to the ALU. Over/underflow flags
// are sticky so the core can halt and report an error code.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   op_valid, op    execute op this cycle
//   push_data       operand for PUSH and REPL
//   clr_err         clears sticky flags (a failing op in the same cycle wins)
//   tos, nos        entries at depth-1 / depth-2, zero when not present
//   depth           occupancy 0..DEPTH
//   empty, full     occupancy status
//   overflow        sticky: op needed more room than available
//   underflow       sticky: op needed more entries than present
module spell_data_stack
   import spell_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       op_valid,
   input  op_t                        op,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           tos,
   output logic [WIDTH-1:0]           nos,
   output logic [$clog2(DEPTH):0]     depth,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;
   localparam logic [DW-1:0] DMAX = DW'(DEPTH);

   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] mem_nxt [DEPTH];

   logic            do_write;
   logic [DW-1:0]   new_depth;
   logic            ovf, unf;

   // Slot indices relative to the current depth. i0 is the first free slot;
   // i1..i3 are TOS, NOS and the third entry. They wrap when the stack is
   // shallow, but are only used once the legality check has passed.
   logic [AW-1:0]   i0, i1, i2, i3;
   assign i0 = depth[AW-1:0];
   assign i1 = i0 - AW'(1);
   assign i2 = i0 - AW'(2);
   assign i3 = i0 - AW'(3);

   assign empty = (depth == '0);
   assign full  = (depth == DMAX);
   assign tos   = (depth >= DW'(1)) ? mem[i1] : '0;
   assign nos   = (depth >= DW'(2)) ? mem[i2] : '0;

   // Legality check. Missing entries are reported before missing room, so
   // DUP on an empty stack is an underflow, never an overflow.
   always_comb begin
      do_write  = 1'b0;
      new_depth = depth;
      ovf       = 1'b0;
      unf       = 1'b0;
      if (op_valid) begin
         case (op)
            PUSH: if (full) ovf = 1'b1;
                  else begin do_write = 1'b1; new_depth = depth + DW'(1); end
            POP:  if (empty) unf = 1'b1;
                  else new_depth = depth - DW'(1);
            DUP:  if (empty) unf = 1'b1;
                  else if (full) ovf = 1'b1;
                  else begin do_write = 1'b1; new_depth = depth + DW'(1); end
            SWAP: if (depth < DW'(2)) unf = 1'b1;
                  else do_write = 1'b1;
            OVER: if (depth < DW'(2)) unf = 1'b1;
                  else if (full) ovf = 1'b1;
                  else begin do_write = 1'b1; new_depth = depth + DW'(1); end
            REPL: if (empty) unf = 1'b1;
                  else do_write = 1'b1;
            ROT:  if (depth < DW'(3)) unf = 1'b1;
                  else do_write = 1'b1;
            default: ;
         endcase
      end
   end

   // Next array contents; entries stay in place, only the top few slots move.
   always_comb begin
      mem_nxt = mem;
      if (do_write) begin
         case (op)
            PUSH: mem_nxt[i0] = push_data;
            DUP:  mem_nxt[i0] = mem[i1];
            OVER: mem_nxt[i0] = mem[i2];
            SWAP: begin
               mem_nxt[i1] = mem[i2];
               mem_nxt[i2] = mem[i1];
            end
            REPL: mem_nxt[i1] = push_data;
            ROT: begin // c b a -> b a c
               mem_nxt[i1] = mem[i3];
               mem_nxt[i2] = mem[i1];
               mem_nxt[i3] = mem[i2];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem       <= '{default: '0};
         depth     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (do_write) mem <= mem_nxt;
         depth     <= new_depth;
         overflow  <= ovf | (overflow  & ~clr_err);
         underflow <= unf | (underflow & ~clr_err);
      end
   end

endmodule

// File: tb/tb_spell_data_stack.sv
module tb_spell_data_stack;
   import spell_pkg::*;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             op_valid;
   op_t              op;
   logic [WIDTH-1:0] push_data;
   logic             clr_err;
   logic [WIDTH-1:0] tos, nos;
   logic [$clog2(DEPTH):0] depth;
   logic             empty, full, overflow, underflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spell_data_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
      .push_data(push_data), .clr_err(clr_err), .tos(tos), .nos(nos),
      .depth(depth), .empty(empty), .full(full),
      .overflow(overflow), .underflow(underflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample just after the edge.
   task automatic cyc(input logic rst, input logic v, input op_t o,
                      input logic [WIDTH-1:0] d, input logic ce);
      reset = rst; op_valid = v; op = o; push_data = d; clr_err = ce;
      @(posedge clk);
      #1;
      reset = 1'b0; op_valid = 1'b0; op = NOP; push_data = '0; clr_err = 1'b0;
   endtask

   task automatic do_op(input op_t o, input logic [WIDTH-1:0] d);
      cyc(1'b0, 1'b1, o, d, 1'b0);
   endtask

   task automatic do_rst();
      cyc(1'b1, 1'b0, NOP, '0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; op_valid = 1'b0; op = NOP; push_data = '0; clr_err = 1'b0;
      do_rst();
      do_rst();
      chk("rst_depth", depth, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full",  full, 0);
      chk("rst_tos",   tos, 0);
      chk("rst_nos",   nos, 0);
      chk("rst_ovf",   overflow, 0);
      chk("rst_unf",   underflow, 0);

      // SWAP / ROT
      do_op(PUSH, 8'h11);
      chk("p1_tos", tos, 8'h11);
      chk("p1_nos", nos, 0);
      do_op(PUSH, 8'h22);
      do_op(PUSH, 8'h33);
      do_op(SWAP, 8'h00);
      chk("swap_tos",   tos, 8'h22);
      chk("swap_nos",   nos, 8'h33);
      chk("swap_depth", depth, 3);
      do_op(ROT, 8'h00);
      chk("rot_tos",   tos, 8'h11);
      chk("rot_nos",   nos, 8'h22);
      chk("rot_depth", depth, 3);
      do_op(POP, 8'h00);
      chk("rot_third", tos, 8'h22);
      chk("rot_third_nos", nos, 8'h33);
      // op_valid low: nothing happens
      cyc(1'b0, 1'b0, PUSH, 8'h77, 1'b0);
      chk("nv_depth", depth, 2);
      chk("nv_tos",   tos, 8'h22);

      // overflow
      do_rst();
      for (int i = 0; i < DEPTH; i++) do_op(PUSH, 8'(i + 1));
      chk("fill_full",  full, 1);
      chk("fill_ovf",   overflow, 0);
      do_op(PUSH, 8'hAA);
      chk("ovf_flag",  overflow, 1);
      chk("ovf_tos",   tos, DEPTH);
      chk("ovf_depth", depth, DEPTH);
      chk("ovf_unf",   underflow, 0);
      do_op(NOP, 8'h00);
      chk("ovf_sticky", overflow, 1);
      cyc(1'b0, 1'b0, NOP, '0, 1'b1);
      chk("ovf_clr", overflow, 0);
      do_op(DUP, 8'h00);
      chk("dup_full_ovf", overflow, 1);
      cyc(1'b0, 1'b1, PUSH, 8'hAA, 1'b1);
      chk("ovf_setwins", overflow, 1);
      chk("ovf_sw_tos", tos, DEPTH);

      // underflow on empty
      do_rst();
      do_op(POP, 8'h00);
      chk("pop_unf",   underflow, 1);
      chk("pop_depth", depth, 0);
      cyc(1'b0, 1'b0, NOP, '0, 1'b1);
      chk("unf_clr", underflow, 0);
      do_op(DUP, 8'h00);
      chk("dup_unf", underflow, 1);
      chk("dup_ovf", overflow, 0);
      chk("dup_depth", depth, 0);

      // OVER / REPL
      do_rst();
      do_op(PUSH, 8'h05);
      do_op(OVER, 8'h00);
      chk("over1_unf",   underflow, 1);
      chk("over1_depth", depth, 1);
      do_op(PUSH, 8'h06);
      do_op(OVER, 8'h00);
      chk("over_tos",   tos, 8'h05);
      chk("over_nos",   nos, 8'h06);
      chk("over_depth", depth, 3);
      do_op(REPL, 8'h0B);
      chk("repl_tos",   tos, 8'h0B);
      chk("repl_nos",   nos, 8'h06);
      chk("repl_depth", depth, 3);
      do_op(ROT, 8'h00);
      chk("rot2_tos", tos, 8'h05);
      chk("rot2_nos", nos, 8'h0B);

      // SWAP with one entry underflows, data untouched
      do_rst();
      do_op(PUSH, 8'h44);
      do_op(SWAP, 8'h00);
      chk("swap1_unf", underflow, 1);
      chk("swap1_tos", tos, 8'h44);

      // reset beats a same-cycle push
      do_rst();
      for (int i = 0; i < 4; i++) do_op(PUSH, 8'(8'h50 + i));
      chk("fill4_depth", depth, 4);
      cyc(1'b1, 1'b1, PUSH, 8'hEE, 1'b0);
      chk("rstpush_depth", depth, 0);
      chk("rstpush_empty", empty, 1);
      chk("rstpush_tos",   tos, 0);
      do_op(PUSH, 8'h12);
      chk("after_rst_tos", tos, 8'h12);
      chk("after_rst_nos", nos, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
